fp_32_divider: RTL and testbench
================================

FP_32_DIVIDER -- requirements
Module: fp_32_divider

Interface
REQ-001 The block SHALL have parameter FLUSH_DENORM, default 1, meaning subnormal inputs are read as signed zero and subnormal results are flushed to signed zero.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rstn, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operand pair is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-006 The block SHALL have port fp_data_1, input, 32 bits: IEEE-754 binary32 dividend.
REQ-007 The block SHALL have port fp_data_2, input, 32 bits: IEEE-754 binary32 divisor.
REQ-008 The block SHALL have port out_valid, output, 1 bit: data_out and flags are valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have port data_out, output, 32 bits: binary32 quotient.
REQ-011 The block SHALL have port flags, output, 4 bits: {invalid, div_by_zero, overflow, underflow}.

Function
REQ-012 The FSM SHALL have states IDLE, PREP, DIV, ROUND and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE with rstn low; operands SHALL be captured on the in_valid&&in_ready edge, with IDLE->PREP.
REQ-014 PREP SHALL unpack and classify both operands, form 24-bit significands with the hidden bit, and compute sign = s1^s2 and exponent = e1-e2+127 in a 10-bit signed value.
REQ-015 PREP with any special operand (NaN, inf, zero) SHALL write the special result, then go PREP->DONE; otherwise PREP->DIV.
REQ-016 DIV SHALL perform restoring division, one quotient bit per cycle, for exactly 26 cycles, counted by a 5-bit counter; sticky = final remainder != 0; then DIV->ROUND.
REQ-017 ROUND SHALL normalize: if the quotient MSB is 0, shift left 1 and decrement the exponent; it SHALL then apply round-to-nearest-even using guard and sticky.
REQ-018 A rounding carry-out SHALL renormalize and increment the exponent.
REQ-019 A final exponent >= 255 SHALL give signed infinity with overflow=1; a final exponent <= 0 SHALL give signed zero with underflow=1.
REQ-020 Special results SHALL be as follows: any NaN, 0/0 or inf/inf gives 0x7FC00000 with invalid=1; x/0 (x finite, nonzero) gives signed inf with div_by_zero=1; inf/x gives signed inf; x/inf and 0/x give signed zero.
REQ-021 Latency SHALL be 28 cycles from the accept edge to out_valid for normal operands, and 2 cycles for specials.
REQ-022 DONE SHALL hold out_valid=1, with data_out and flags stable, until out_valid&&out_ready; then DONE->IDLE and out_valid drops the next cycle.
REQ-023 in_valid SHALL be ignored outside IDLE; there SHALL be exactly one bubble cycle between result transfer and the next accept.
REQ-024 data_out and flags SHALL keep their last value after transfer until the next result is written.

Reset
REQ-025 While rstn=1 at a clock edge, the block SHALL set state=IDLE and zero the counter, data_out, flags and out_valid; in_ready SHALL be 0 while rstn=1.
REQ-026 Reset asserted in any state, including mid-DIV, SHALL abandon the operation with no result delivered; in_ready SHALL be 1 in the first cycle after rstn falls.

Structure
REQ-027 Shared package fp_32_pkg SHALL hold EXP_W=8, MAN_W=23, BIAS=127, QNAN=32'h7FC00000, the FSM state enum and the flag bit indices.
REQ-028 Operand classification (zero/subnormal/inf/NaN/normal plus field split) SHALL be one sub-module, fp_32_classify, instantiated twice.

Verification
REQ-029 A bench SHALL check 0x40C00000 / 0x40400000 (6/3) -> data_out 0x40000000, flags 0, out_valid 28 cycles after accept.
REQ-030 A bench SHALL check 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB, confirming the round-up path.
REQ-031 A bench SHALL check 0x3F800000 / 0x00000000 -> 0x7F800000, flags 4'b0100; then 0x00000000 / 0x80000000 -> 0x7FC00000, flags 4'b1000; both with 2-cycle latency.
REQ-032 A bench SHALL check 0x7F7FFFFF / 0x3F000000 -> 0x7F800000, flags 4'b0010; and 0x00800000 / 0x40000000 -> 0x00000000, flags 4'b0001.
REQ-033 A bench SHALL check that holding out_ready=0 for 10 cycles in DONE keeps out_valid=1, data_out stable and in_ready=0; after the transfer, in_ready=1 exactly one cycle later.
REQ-034 A bench SHALL check that rstn=1 for one cycle at DIV iteration 10 gives out_valid=0, data_out=0 and in_ready=1 the following cycle; a fresh 6/3 then returns 0x40000000.

Source files
------------

// File: rtl/fp_32_pkg.sv
// Shared definitions for the binary32 divider.
//   EXP_W/MAN_W/BIAS : binary32 field widths and exponent bias
//   QNAN             : canonical quiet NaN returned for invalid operations
//   F_*              : bit positions inside the 4-bit flags word
//   state_t          : divider FSM states
//   fp_class_t       : per-operand classification and unpacked significand
package fp_32_pkg;

  localparam int          EXP_W     = 8;
  localparam int          MAN_W     = 23;
  localparam int          BIAS      = 127;
  localparam logic [31:0] QNAN      = 32'h7FC00000;
  localparam int          DIV_ITERS = 26;   // 24 significand bits + guard + round

  // flags = {invalid, div_by_zero, overflow, underflow}
  localparam int F_INVALID   = 3;
  localparam int F_DIVZERO   = 2;
  localparam int F_OVERFLOW  = 1;
  localparam int F_UNDERFLOW = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    DIV   = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic               sign;
    logic               is_zero;
    logic               is_sub;
    logic               is_inf;
    logic               is_nan;
    logic               is_norm;
    logic [23:0]        sig;      // significand with hidden bit, MSB set when nonzero
    logic signed [9:0]  exp_eff;  // unbiased-offset exponent matching sig
  } fp_class_t;

endpackage

// File: rtl/fp_32_classify.sv
// Splits a binary32 word into sign/exponent/fraction and classifies it.
//   fp  : binary32 operand
//   cls : classification flags, 24-bit significand with hidden bit, exponent
// When FLUSH_DENORM is set a subnormal reads as signed zero; otherwise it is
// normalized here so the divider core only ever sees a leading-one significand.
module fp_32_classify
  import fp_32_pkg::*;
#(
  parameter bit FLUSH_DENORM = 1'b1
) (
  input  logic [31:0] fp,
  output fp_class_t   cls
);

  logic [EXP_W-1:0] e;
  logic [MAN_W-1:0] m;
  logic             e_max, e_zero, m_nz;
  logic [4:0]       lz;
  logic             found;

  assign e      = fp[MAN_W +: EXP_W];
  assign m      = fp[MAN_W-1:0];
  assign e_max  = &e;
  assign e_zero = ~|e;
  assign m_nz   = |m;

  always_comb begin
    cls         = '0;
    cls.sign    = fp[31];
    cls.is_nan  = e_max & m_nz;
    cls.is_inf  = e_max & ~m_nz;
    cls.is_zero = e_zero & (~m_nz | FLUSH_DENORM);
    cls.is_sub  = e_zero & m_nz & ~FLUSH_DENORM;
    cls.is_norm = ~e_zero & ~e_max;

    // leading zeros of the fraction, used only for subnormal normalization
    lz    = '0;
    found = 1'b0;
    for (int i = MAN_W - 1; i >= 0; i--) begin
      if (!found) begin
        if (m[i]) found = 1'b1;
        else      lz    = lz + 5'd1;
      end
    end

    if (cls.is_sub) begin
      // value = 0.m * 2^(1-BIAS); shifting the first one into bit 23 costs lz+1
      cls.sig     = {1'b0, m} << (lz + 5'd1);
      cls.exp_eff = 10'sd0 - $signed({5'd0, lz});
    end else if (cls.is_norm) begin
      cls.sig     = {1'b1, m};
      cls.exp_eff = $signed({2'b00, e});
    end
  end

endmodule

// File: rtl/fp_32_divider.sv
// Multi-cycle IEEE-754 binary32 divider, restoring radix-2, round-to-nearest-even.
//   clk, rstn            : clock, synchronous active-high reset
//   in_valid/in_ready    : operand handshake (fp_data_1 / fp_data_2)
//   out_valid/out_ready  : result handshake (data_out, flags)
//   flags                : {invalid, div_by_zero, overflow, underflow}
// Normal operands: PREP, 26 DIV cycles, ROUND -> out_valid 28 cycles after accept.
// Special operands: PREP writes the result and jumps to DONE; out_valid rises
// on the following cycle, giving a 2-cycle latency.
module fp_32_divider
  import fp_32_pkg::*;
#(
  parameter int FLUSH_DENORM = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp_data_1,
  input  logic [31:0] fp_data_2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] data_out,
  output logic [3:0]  flags
);

  localparam logic signed [9:0] BIAS_S   = 10'(BIAS);
  localparam logic [4:0]        DIV_LAST = 5'(DIV_ITERS - 1);

  state_t            state;
  logic [31:0]       op_a, op_b;
  fp_class_t         ca, cb;
  logic              res_sign;
  logic signed [9:0] res_exp;
  logic [23:0]       divisor;
  logic [24:0]       rem;
  logic [25:0]       quo;
  logic [4:0]        cnt;

  fp_32_classify #(.FLUSH_DENORM(FLUSH_DENORM != 0)) u_cls_a (.fp(op_a), .cls(ca));
  fp_32_classify #(.FLUSH_DENORM(FLUSH_DENORM != 0)) u_cls_b (.fp(op_b), .cls(cb));

  assign in_ready = (state == IDLE) && !rstn;

  // ---- special-operand result ----
  logic        is_special, sp_sign;
  logic [31:0] sp_data;
  logic [3:0]  sp_flags;

  always_comb begin
    is_special = !(ca.is_norm || ca.is_sub) || !(cb.is_norm || cb.is_sub);
    sp_sign    = ca.sign ^ cb.sign;
    sp_flags   = '0;
    if (ca.is_nan || cb.is_nan || (ca.is_zero && cb.is_zero) || (ca.is_inf && cb.is_inf)) begin
      sp_data             = QNAN;
      sp_flags[F_INVALID] = 1'b1;
    end else if (ca.is_inf) begin
      sp_data = {sp_sign, 8'hFF, 23'd0};
    end else if (cb.is_zero) begin
      sp_data             = {sp_sign, 8'hFF, 23'd0};
      sp_flags[F_DIVZERO] = 1'b1;
    end else begin
      // zero dividend or infinite divisor
      sp_data = {sp_sign, 31'd0};
    end
  end

  // ---- one restoring-division step ----
  // rem stays below 2*divisor, so a successful subtract always fits 24 bits
  logic        ge;
  logic [23:0] diff;
  logic [24:0] rem_nxt;

  assign ge      = rem >= {1'b0, divisor};
  assign diff    = rem[23:0] - divisor;
  assign rem_nxt = {(ge ? diff : rem[23:0]), 1'b0};

  // ---- normalize, round, range check ----
  // quo = floor(m1/m2 * 2^25): bit 25 set means quotient in [1,2)
  logic [25:0]       nq;
  logic signed [9:0] nexp, fexp;
  logic [23:0]       mant;
  logic              guard, sticky, rup;
  logic [24:0]       mant_r;
  logic [22:0]       frac;
  logic [31:0]       rnd_data;
  logic [3:0]        rnd_flags;

  always_comb begin
    nq        = quo[25] ? quo : {quo[24:0], 1'b0};
    nexp      = quo[25] ? res_exp : res_exp - 10'sd1;
    mant      = nq[25:2];
    guard     = nq[1];
    sticky    = nq[0] | (|rem);
    rup       = guard & (sticky | mant[0]);
    mant_r    = {1'b0, mant} + {24'd0, rup};
    // carry-out means mantissa became 2.0: shift right and bump exponent
    frac      = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
    fexp      = nexp + $signed({9'd0, mant_r[24]});
    rnd_flags = '0;
    if (fexp >= 10'sd255) begin
      rnd_data               = {res_sign, 8'hFF, 23'd0};
      rnd_flags[F_OVERFLOW]  = 1'b1;
    end else if (fexp <= 10'sd0) begin
      rnd_data               = {res_sign, 31'd0};
      rnd_flags[F_UNDERFLOW] = 1'b1;
    end else begin
      rnd_data               = {res_sign, fexp[7:0], frac};
    end
  end

  // ---- control FSM ----
  always_ff @(posedge clk) begin
    if (rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      data_out  <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a  <= fp_data_1;
            op_b  <= fp_data_2;
            state <= PREP;
          end
        end
        PREP: begin
          res_sign <= ca.sign ^ cb.sign;
          res_exp  <= ca.exp_eff - cb.exp_eff + BIAS_S;
          rem      <= {1'b0, ca.sig};
          divisor  <= cb.sig;
          quo      <= '0;
          cnt      <= '0;
          if (is_special) begin
            data_out <= sp_data;
            flags    <= sp_flags;
            state    <= DONE;
          end else begin
            state    <= DIV;
          end
        end
        DIV: begin
          rem <= rem_nxt;
          quo <= {quo[24:0], ge};
          cnt <= cnt + 5'd1;
          if (cnt == DIV_LAST) state <= ROUND;
        end
        ROUND: begin
          data_out  <= rnd_data;
          flags     <= rnd_flags;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          // specials arrive here with out_valid low and raise it one cycle later
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_32_divider.sv
// Directed, table-driven bench for fp_32_divider plus handshake/reset sequences.
module tb_fp_32_divider;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fp_data_1, fp_data_2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic [3:0]  flags;

  fp_32_divider #(.FLUSH_DENORM(1)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fp_data_1 (fp_data_1),
    .fp_data_2 (fp_data_2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  // waits for in_ready, presents one operand pair, returns cycles to out_valid
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    fp_data_1 = x;
    fp_data_2 = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [3:0]  f;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;

    vecs[0]  = '{32'h40C00000, 32'h40400000, 32'h40000000, 4'b0000, 28, "6/3"};
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 28, "1/3"};
    vecs[2]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 2,  "1/0"};
    vecs[3]  = '{32'h00000000, 32'h80000000, 32'h7FC00000, 4'b1000, 2,  "0/-0"};
    vecs[4]  = '{32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 4'b0010, 28, "max/0.5"};
    vecs[5]  = '{32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 28, "minnorm/2"};
    vecs[6]  = '{32'hC0C00000, 32'h40400000, 32'hC0000000, 4'b0000, 28, "-6/3"};
    vecs[7]  = '{32'h40400000, 32'h40000000, 32'h3FC00000, 4'b0000, 28, "3/2"};
    vecs[8]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b1000, 2,  "nan/1"};
    vecs[9]  = '{32'hFF800000, 32'h7F800000, 32'h7FC00000, 4'b1000, 2,  "-inf/inf"};
    vecs[10] = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000, 2,  "inf/-2"};
    vecs[11] = '{32'h40000000, 32'h7F800000, 32'h00000000, 4'b0000, 2,  "2/inf"};
    vecs[12] = '{32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0100, 2,  "-1/0"};
    vecs[13] = '{32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 2,  "subnorm/1"};
    vecs[14] = '{32'h3F800000, 32'h40E00000, 32'h3E124925, 4'b0000, 28, "1/7"};
    vecs[15] = '{32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000, 2,  "-0/1"};

    rstn      = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    fp_data_1 = '0;
    fp_data_2 = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data_out",  data_out,           32'd0);
    chk("rst_flags",     {28'd0, flags},     32'd0);
    rstn = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // vector table
    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].a, vecs[i].b, lat);
      chk({vecs[i].name, " data"},    data_out,            vecs[i].q);
      chk({vecs[i].name, " flags"},   {28'd0, flags},      {28'd0, vecs[i].f});
      chk({vecs[i].name, " latency"}, lat,                 vecs[i].lat);
      @(posedge clk); #1;
      chk({vecs[i].name, " drop"},    {31'd0, out_valid},  32'd0);
    end

    // back-pressure in DONE; in_valid asserted meanwhile must be ignored
    out_ready = 1'b0;
    run_op(32'h40C00000, 32'h40400000, lat);
    chk("bp latency", lat, 28);
    in_valid  = 1'b1;
    fp_data_1 = 32'h3F800000;
    fp_data_2 = 32'h40400000;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp data_out",  data_out,           32'h40000000);
      chk("bp in_ready",  {31'd0, in_ready},  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp in_ready pre-xfer", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("xfer out_valid", {31'd0, out_valid}, 32'd0);
    chk("xfer in_ready",  {31'd0, in_ready},  32'd1);
    chk("xfer data kept", data_out,           32'h40000000);
    chk("xfer flags kept", {28'd0, flags},    32'd0);

    // reset at DIV iteration 10
    in_valid  = 1'b1;
    fp_data_1 = 32'h3F800000;
    fp_data_2 = 32'h40400000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    chk("middiv out_valid", {31'd0, out_valid}, 32'd0);
    rstn = 1'b1;
    #1;
    chk("middiv in_ready during rst", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk("middiv rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("middiv rst data_out",  data_out,           32'd0);
    chk("middiv rst flags",     {28'd0, flags},     32'd0);
    chk("middiv rst in_ready",  {31'd0, in_ready},  32'd1);
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("middiv no result", seen, 0);
    run_op(32'h40C00000, 32'h40400000, lat);
    chk("fresh 6/3 data",    data_out,       32'h40000000);
    chk("fresh 6/3 flags",   {28'd0, flags}, 32'd0);
    chk("fresh 6/3 latency", lat,            28);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
